// File: rtl/qos_pkg.sv
// Shared QoS definitions: VC count, egress FSM states and one-hot grant helpers
// used by both the VC arbiter and the egress mux.
package qos_pkg;

   localparam int NUM_VC   = 4;
   localparam int VC_IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   function automatic logic is_onehot4(input logic [NUM_VC-1:0] v);
      return (v != '0) && ((v & (v - 4'd1)) == '0);
   endfunction

   function automatic logic [VC_IDX_W-1:0] onehot4_to_idx(input logic [NUM_VC-1:0] v);
      logic [VC_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (v[i]) idx = VC_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/qos_out_reg.sv
// Single-entry registered valid/ready stage; accepts a new word whenever the
// slot is empty or is being drained in the same cycle.
module qos_out_reg #(
   parameter int W = 35
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         slot_free,
   output logic         valid,
   output logic [W-1:0] data
);

   assign slot_free = !valid || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/qos_vc_egress_mux.sv
// Latches the arbiter grant and streams the selected VC's packet to the egress
// link. Optional per-VC packet counters are enabled with QOS_PKT_CNT_EN.
module qos_vc_egress_mux
   import qos_pkg::*;
#(
   parameter int DW        = 32,
   parameter int MAX_WORDS = 64,
   parameter int CNT_W     = 7
) (
`ifdef QOS_PKT_CNT_EN
   output logic [63:0]          pkt_cnt,
`endif
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_VC-1:0]    grant,
   input  logic [NUM_VC*DW-1:0] vc_data,
   input  logic [NUM_VC-1:0]    vc_valid,
   input  logic [NUM_VC-1:0]    vc_eop,
   output logic [NUM_VC-1:0]    vc_ready,
   output logic [DW-1:0]        out_data,
   output logic                 out_valid,
   output logic                 out_eop,
   output logic [VC_IDX_W-1:0]  out_vc,
   input  logic                 out_ready,
   output logic                 pkt_start,
   output logic                 pkt_done,
   output logic                 err_grant,
   output logic                 err_len
);

   localparam int PW = DW + 1 + VC_IDX_W;

   state_t                state, state_nxt;
   logic [VC_IDX_W-1:0]   cur_vc;
   logic [CNT_W-1:0]      word_cnt;
   logic                  grant_ok, grant_bad, start;
   logic [VC_IDX_W-1:0]   grant_idx;
   logic                  sel_valid, sel_eop, slot_free, hs, at_limit, last;
   logic [DW-1:0]         sel_data;
   logic [PW-1:0]         held;

   assign grant_ok  = is_onehot4(grant);
   assign grant_idx = onehot4_to_idx(grant);
   assign grant_bad = (grant != '0) && !grant_ok;
   assign start     = (state == IDLE) && grant_ok && vc_valid[grant_idx];

   assign sel_valid = vc_valid[cur_vc];
   assign sel_eop   = vc_eop[cur_vc];
   assign sel_data  = vc_data[int'(cur_vc)*DW +: DW];
   assign hs        = (state == XFER) && sel_valid && slot_free;
   // The word being accepted is number word_cnt+1; the MAX_WORDS-th one is forced last.
   assign at_limit  = (word_cnt == CNT_W'(MAX_WORDS - 1));
   assign last      = sel_eop || at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = XFER;
         XFER:    if (hs && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      vc_ready = '0;
      if (state == XFER) vc_ready[cur_vc] = sel_valid && slot_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_vc    <= '0;
         word_cnt  <= '0;
         pkt_start <= 1'b0;
         pkt_done  <= 1'b0;
         err_grant <= 1'b0;
         err_len   <= 1'b0;
      end else begin
         pkt_start <= start;
         pkt_done  <= hs && last;
         if (start) begin
            cur_vc   <= grant_idx;
            word_cnt <= '0;
         end else if (hs) begin
            word_cnt <= word_cnt + CNT_W'(1);
         end
         if ((state == IDLE) && grant_bad) err_grant <= 1'b1;
         if (hs && at_limit && !sel_eop)   err_len   <= 1'b1;
      end
   end

`ifdef QOS_PKT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt <= '0;
      end else if (hs && last) begin
         pkt_cnt[16*int'(cur_vc) +: 16] <= pkt_cnt[16*int'(cur_vc) +: 16] + 16'd1;
      end
   end
`endif

   qos_out_reg #(.W(PW)) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (hs),
      .load_data ({cur_vc, last, sel_data}),
      .ready     (out_ready),
      .slot_free (slot_free),
      .valid     (out_valid),
      .data      (held)
   );

   assign out_data = held[DW-1:0];
   assign out_eop  = held[DW];
   assign out_vc   = held[DW+1 +: VC_IDX_W];

endmodule

// File: tb/tb_qos_vc_egress_mux.sv
// Directed bench for qos_vc_egress_mux with MAX_WORDS=4 so the over-length
// path is reachable with short packets.
module tb_qos_vc_egress_mux;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   grant, vc_valid, vc_eop, vc_ready;
   logic [127:0] vc_data;
   logic [31:0]  out_data;
   logic         out_valid, out_eop, out_ready;
   logic [1:0]   out_vc;
   logic         pkt_start, pkt_done, err_grant, err_len;

   int checks = 0;
   int errors = 0;

   qos_vc_egress_mux #(.DW(32), .MAX_WORDS(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .grant(grant), .vc_data(vc_data),
      .vc_valid(vc_valid), .vc_eop(vc_eop), .vc_ready(vc_ready),
      .out_data(out_data), .out_valid(out_valid), .out_eop(out_eop),
      .out_vc(out_vc), .out_ready(out_ready), .pkt_start(pkt_start),
      .pkt_done(pkt_done), .err_grant(err_grant), .err_len(err_len)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vc(input int v, input logic val, input logic [31:0] d, input logic e);
      vc_valid[v]        = val;
      vc_data[v*32 +: 32] = d;
      vc_eop[v]          = e;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; grant = '0; vc_valid = '0; vc_eop = '0; vc_data = '0; out_ready = 1'b1;
      #1;
      checks++; if ({out_valid, out_eop, out_vc, pkt_start, pkt_done, vc_ready, out_data} !== 42'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", {out_valid, out_eop, out_vc, pkt_start, pkt_done, vc_ready, out_data}); end
      checks++; if ({err_grant, err_len} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b exp 00", {err_grant, err_len}); end
      #1 rst_n = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_basic();
      cyc(); grant = 4'b0100; set_vc(2, 1, 32'hA000_000A, 0); #1;
      checks++; if (vc_ready !== 4'b0000) begin errors++; $display("FAIL basic_idle_ready: got %b exp 0000", vc_ready); end
      checks++; if (pkt_start !== 1'b0) begin errors++; $display("FAIL basic_start_early: got %b exp 0", pkt_start); end
      cyc(); grant = 4'b0000; #1;
      checks++; if (pkt_start !== 1'b1) begin errors++; $display("FAIL basic_start: got %b exp 1", pkt_start); end
      checks++; if (vc_ready !== 4'b0100) begin errors++; $display("FAIL basic_xfer_ready: got %b exp 0100", vc_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c1: got %b exp 0", out_valid); end
      cyc(); set_vc(2, 1, 32'hB000_000B, 0); #1;
      checks++; if ({out_valid, out_vc, out_eop, out_data} !== {1'b1, 2'd2, 1'b0, 32'hA000_000A}) begin errors++; $display("FAIL basic_word_a: got v%b vc%0d e%b %h", out_valid, out_vc, out_eop, out_data); end
      checks++; if (pkt_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse: got %b exp 0", pkt_start); end
      cyc(); set_vc(2, 1, 32'hC000_000C, 1); #1;
      checks++; if ({out_valid, out_eop, out_data} !== {1'b1, 1'b0, 32'hB000_000B}) begin errors++; $display("FAIL basic_word_b: got v%b e%b %h", out_valid, out_eop, out_data); end
      cyc(); set_vc(2, 0, 0, 0); #1;
      checks++; if ({out_valid, out_eop, out_vc, out_data} !== {1'b1, 1'b1, 2'd2, 32'hC000_000C}) begin errors++; $display("FAIL basic_word_c: got v%b e%b vc%0d %h", out_valid, out_eop, out_vc, out_data); end
      checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b exp 1", pkt_done); end
      cyc(); #1;
      checks++; if ({out_valid, pkt_done} !== 2'b00) begin errors++; $display("FAIL basic_drain: got %b exp 00", {out_valid, pkt_done}); end
   endtask

   task automatic test_backpressure();
      cyc(); grant = 4'b0100; set_vc(2, 1, 32'hD000_000D, 0); #1;
      cyc(); grant = 4'b0000; #1;
      cyc(); set_vc(2, 1, 32'hE000_000E, 0); #1;
      checks++; if (out_data !== 32'hD000_000D) begin errors++; $display("FAIL bp_word_d: got %h exp d000000d", out_data); end
      cyc(); set_vc(2, 1, 32'hF000_000F, 1); out_ready = 1'b0; #1;
      checks++; if (out_data !== 32'hE000_000E) begin errors++; $display("FAIL bp_word_e: got %h exp e000000e", out_data); end
      checks++; if (vc_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_low: got %b exp 0000", vc_ready); end
      for (int k = 0; k < 2; k++) begin
         cyc(); #1;
         checks++; if ({out_valid, out_eop, out_data} !== {1'b1, 1'b0, 32'hE000_000E}) begin errors++; $display("FAIL bp_hold_%0d: got v%b e%b %h", k, out_valid, out_eop, out_data); end
         checks++; if (vc_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_hold_%0d: got %b exp 0000", k, vc_ready); end
      end
      cyc(); out_ready = 1'b1; #1;
      checks++; if (out_data !== 32'hE000_000E) begin errors++; $display("FAIL bp_hold_last: got %h exp e000000e", out_data); end
      checks++; if (vc_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b exp 0100", vc_ready); end
      cyc(); set_vc(2, 0, 0, 0); #1;
      checks++; if ({out_valid, out_eop, pkt_done, out_data} !== {1'b1, 1'b1, 1'b1, 32'hF000_000F}) begin errors++; $display("FAIL bp_word_f: got v%b e%b d%b %h", out_valid, out_eop, pkt_done, out_data); end
      cyc(); #1;
   endtask

   task automatic test_grant_change();
      cyc(); grant = 4'b0100; set_vc(2, 1, 32'h1111_0000, 0); set_vc(0, 1, 32'h2222_0000, 1); #1;
      cyc(); grant = 4'b0001; #1;
      checks++; if (vc_ready !== 4'b0100) begin errors++; $display("FAIL gc_ready_vc2: got %b exp 0100", vc_ready); end
      cyc(); set_vc(2, 1, 32'h1111_0001, 1); #1;
      checks++; if ({out_vc, out_data} !== {2'd2, 32'h1111_0000}) begin errors++; $display("FAIL gc_word0: got vc%0d %h", out_vc, out_data); end
      checks++; if (vc_ready !== 4'b0100) begin errors++; $display("FAIL gc_ready_hold: got %b exp 0100", vc_ready); end
      cyc(); set_vc(2, 0, 0, 0); #1;
      checks++; if ({out_vc, out_eop, pkt_done, out_data} !== {2'd2, 1'b1, 1'b1, 32'h1111_0001}) begin errors++; $display("FAIL gc_word1: got vc%0d e%b d%b %h", out_vc, out_eop, pkt_done, out_data); end
      checks++; if (vc_ready !== 4'b0000) begin errors++; $display("FAIL gc_idle_gap: got %b exp 0000", vc_ready); end
      cyc(); grant = 4'b0000; #1;
      checks++; if ({pkt_start, out_valid, vc_ready} !== {1'b1, 1'b0, 4'b0001}) begin errors++; $display("FAIL gc_vc0_start: got s%b v%b r%b", pkt_start, out_valid, vc_ready); end
      cyc(); set_vc(0, 0, 0, 0); #1;
      checks++; if ({out_vc, out_eop, pkt_done, out_data} !== {2'd0, 1'b1, 1'b1, 32'h2222_0000}) begin errors++; $display("FAIL gc_vc0_word: got vc%0d e%b d%b %h", out_vc, out_eop, pkt_done, out_data); end
      cyc(); #1;
   endtask

   task automatic test_illegal_grant();
      cyc(); grant = 4'b0110; set_vc(1, 1, 32'h3333_0001, 1); set_vc(2, 1, 32'h3333_0002, 1); #1;
      checks++; if ({err_grant, vc_ready} !== 5'b0_0000) begin errors++; $display("FAIL ill_before: got e%b r%b exp 0/0000", err_grant, vc_ready); end
      cyc(); grant = 4'b0000; set_vc(1, 0, 0, 0); set_vc(2, 0, 0, 0); #1;
      checks++; if (err_grant !== 1'b1) begin errors++; $display("FAIL ill_err_set: got %b exp 1", err_grant); end
      checks++; if ({pkt_start, out_valid, vc_ready} !== 6'b0) begin errors++; $display("FAIL ill_no_start: got s%b v%b r%b", pkt_start, out_valid, vc_ready); end
      cyc(); cyc(); #1;
      checks++; if (err_grant !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b exp 1", err_grant); end
   endtask

   task automatic test_overlen();
      cyc(); grant = 4'b0001; set_vc(0, 1, 32'h0000_0001, 0); #1;
      cyc(); grant = 4'b0000; #1;
      for (int w = 2; w <= 4; w++) begin
         cyc(); set_vc(0, 1, 32'(w), 0); #1;
         checks++; if ({out_eop, out_data} !== {1'b0, 32'(w - 1)}) begin errors++; $display("FAIL ol_word%0d: got e%b %h", w - 1, out_eop, out_data); end
      end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL ol_err_early: got %b exp 0", err_len); end
      cyc(); set_vc(0, 1, 32'h0000_0005, 0); #1;
      checks++; if ({out_valid, out_vc, out_eop, pkt_done, out_data} !== {1'b1, 2'd0, 1'b1, 1'b1, 32'h0000_0004}) begin errors++; $display("FAIL ol_forced: got v%b vc%0d e%b d%b %h", out_valid, out_vc, out_eop, pkt_done, out_data); end
      checks++; if ({err_len, vc_ready} !== 5'b1_0000) begin errors++; $display("FAIL ol_err_set: got e%b r%b exp 1/0000", err_len, vc_ready); end
      cyc(); grant = 4'b0001; #1;
      checks++; if ({out_valid, pkt_start} !== 2'b00) begin errors++; $display("FAIL ol_gap: got %b exp 00", {out_valid, pkt_start}); end
      cyc(); grant = 4'b0000; #1;
      checks++; if ({pkt_start, vc_ready} !== 5'b1_0001) begin errors++; $display("FAIL ol_restart: got s%b r%b", pkt_start, vc_ready); end
      cyc(); set_vc(0, 1, 32'h0000_0006, 1); #1;
      checks++; if ({out_eop, out_data} !== {1'b0, 32'h0000_0005}) begin errors++; $display("FAIL ol_word5: got e%b %h", out_eop, out_data); end
      cyc(); set_vc(0, 0, 0, 0); #1;
      checks++; if ({out_eop, pkt_done, err_len, out_data} !== {1'b1, 1'b1, 1'b1, 32'h0000_0006}) begin errors++; $display("FAIL ol_word6: got e%b d%b l%b %h", out_eop, pkt_done, err_len, out_data); end
      cyc(); #1;
   endtask

   task automatic test_reset_mid();
      cyc(); grant = 4'b0010; set_vc(1, 1, 32'h7777_0001, 0); #1;
      cyc(); grant = 4'b0000; #1;
      cyc(); #1;
      checks++; if ({out_valid, out_vc, err_grant, err_len} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL mid_pre: got v%b vc%0d g%b l%b", out_valid, out_vc, err_grant, err_len); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, out_eop, out_vc, pkt_start, pkt_done, vc_ready, out_data} !== 42'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h exp 0", {out_valid, out_eop, out_vc, pkt_start, pkt_done, vc_ready, out_data}); end
      checks++; if ({err_grant, err_len} !== 2'b00) begin errors++; $display("FAIL mid_reset_errs: got %b exp 00", {err_grant, err_len}); end
      set_vc(1, 0, 0, 0);
      #2 rst_n = 1'b1;
      cyc(); #1;
      checks++; if ({out_valid, vc_ready, pkt_start} !== 6'b0) begin errors++; $display("FAIL mid_after: got v%b r%b s%b", out_valid, vc_ready, pkt_start); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_grant_change();
      test_illegal_grant();
      test_overlen();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
